// File: rtl/fetch_stage.sv
// =============================================================================
// fetch_stage
// -----------------------------------------------------------------------------
// Instruction-fetch (IF) stage of the 5-stage WISC pipeline. Holds the program
// counter, drives the instruction-memory address and owns the IF/ID pipeline
// register consumed by the decode stage. Conditional branches (B, opcode 4'hC)
// can be predicted with a table of 2-bit saturating counters.
//
// Optional feature (macro BHT_PREDICT_EN):
//   defined   : a 2^BHT_IDX_BITS-entry counter table, indexed by
//               PC[BHT_IDX_BITS:1], predicts B instructions. When the table
//               predicts taken, the PC jumps to the branch target.
//   undefined : no table. Every B is fetched not-taken and decode corrects it.
//               The Resolve* inputs are ignored.
//
// Ports:
//   clk            clock
//   rst            asynchronous reset, active-high
//   PCF            instruction-memory address (current PC)
//   InstrF         instruction returned for PCF in the same cycle
//   IMemReady      InstrF is valid this cycle (0 = cache miss, wait)
//   Stall          decode stall: hold the PC and IF/ID
//   BranchD        misprediction redirect from decode (overrides Stall)
//   BranchAddr     redirect target
//   ResolveValid   a B/BR was resolved in decode this cycle
//   ResolvePC      PC of the resolved branch
//   ResolveTaken   actual outcome of the resolved branch
//   InstructionD   IF/ID instruction
//   PCPlus2D       IF/ID PC+2
//   PredictedTaken IF/ID prediction bit
//   ValidD         1 = IF/ID holds a real instruction, 0 = bubble
// =============================================================================
module fetch_stage #(
    parameter int          BHT_IDX_BITS = 4,
    parameter logic [15:0] NOP_INSTR    = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] PCF,
    input  logic [15:0] InstrF,
    input  logic        IMemReady,
    input  logic        Stall,
    input  logic        BranchD,
    input  logic [15:0] BranchAddr,
    input  logic        ResolveValid,
    input  logic [15:0] ResolvePC,
    input  logic        ResolveTaken,
    output logic [15:0] InstructionD,
    output logic [15:0] PCPlus2D,
    output logic        PredictedTaken,
    output logic        ValidD
);

    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    logic [15:0] pc_reg,    pc_next;
    logic [15:0] instr_reg, instr_next;
    logic [15:0] pc2_reg,   pc2_next;
    logic        pred_reg,  pred_next;
    logic        valid_reg, valid_next;

    // -------------------------------------------------------------------------
    // Fetch datapath
    // -------------------------------------------------------------------------
    logic [15:0] pc_plus2;
    logic [15:0] branch_offset;
    logic [15:0] branch_target;
    logic        is_b;
    logic        is_hlt;
    logic        pred_f;

    // 16-bit adders wrap naturally, giving the mod 2^16 PC arithmetic.
    assign pc_plus2      = pc_reg + 16'd2;
    assign branch_offset = {{6{InstrF[8]}}, InstrF[8:0], 1'b0};
    assign branch_target = pc_plus2 + branch_offset;
    assign is_b          = (InstrF[15:12] == OP_B);
    assign is_hlt        = (InstrF[15:12] == OP_HLT);

`ifdef BHT_PREDICT_EN
    // -------------------------------------------------------------------------
    // Branch history table: 2-bit saturating counters, reset weakly not-taken.
    // A read and an update of the same entry in one cycle return the old
    // value; the new value is seen from the following cycle.
    // -------------------------------------------------------------------------
    localparam int BHT_ENTRIES = 1 << BHT_IDX_BITS;

    logic [1:0]              bht_reg [0:BHT_ENTRIES-1];
    logic [BHT_IDX_BITS-1:0] fetch_idx;
    logic [BHT_IDX_BITS-1:0] resolve_idx;
    logic [1:0]              cnt_cur;
    logic [1:0]              cnt_next;
    logic                    unused_resolve_bits;

    // Bit 0 of a PC is always zero, so it never takes part in the index.
    assign fetch_idx   = pc_reg[BHT_IDX_BITS:1];
    assign resolve_idx = ResolvePC[BHT_IDX_BITS:1];
    assign cnt_cur     = bht_reg[resolve_idx];
    assign unused_resolve_bits = ^{ResolvePC[15:BHT_IDX_BITS+1], ResolvePC[0]};

    always_comb begin
        cnt_next = cnt_cur;
        if (ResolveTaken) begin
            if (cnt_cur != 2'b11) begin
                cnt_next = cnt_cur + 2'b01;
            end
        end else begin
            if (cnt_cur != 2'b00) begin
                cnt_next = cnt_cur - 2'b01;
            end
        end
    end

    // Updates are independent of the fetch pipeline: they proceed through
    // stalls, memory waits and redirects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_reg[i] <= 2'b01;
            end
        end else if (ResolveValid) begin
            bht_reg[resolve_idx] <= cnt_next;
        end
    end

    // Prediction needs a valid B word; the counter's MSB is the direction.
    assign pred_f = is_b & IMemReady & bht_reg[fetch_idx][1];
`else
    // No predictor: B is always fetched not-taken, resolution is ignored.
    logic unused_resolve;
    logic unused_target;

    assign unused_resolve = ^{ResolveValid, ResolvePC, ResolveTaken};
    assign unused_target  = ^{branch_target, is_b};
    assign pred_f         = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state selection, highest priority first:
    // redirect, stall, memory wait, halt, normal fetch.
    // -------------------------------------------------------------------------
    always_comb begin
        pc_next    = pc_reg;
        instr_next = instr_reg;
        pc2_next   = pc2_reg;
        pred_next  = pred_reg;
        valid_next = valid_reg;

        if (BranchD) begin
            // Redirect wins even over a stall: the stalled instruction in
            // IF/ID is on the wrong path and gets squashed.
            pc_next    = BranchAddr;
            instr_next = NOP_INSTR;
            pc2_next   = 16'h0000;
            pred_next  = 1'b0;
            valid_next = 1'b0;
        end else if (Stall) begin
            // Hold everything (defaults).
        end else if (!IMemReady) begin
            // Cache miss: keep asking for the same PC, push a bubble.
            instr_next = NOP_INSTR;
            pc2_next   = 16'h0000;
            pred_next  = 1'b0;
            valid_next = 1'b0;
        end else if (is_hlt) begin
            // HLT parks the PC so it is re-fetched until decode redirects.
            instr_next = InstrF;
            pc2_next   = pc_plus2;
            pred_next  = 1'b0;
            valid_next = 1'b1;
        end else begin
            instr_next = InstrF;
            pc2_next   = pc_plus2;
            pred_next  = pred_f;
            valid_next = 1'b1;
            pc_next    = pred_f ? branch_target : pc_plus2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg    <= 16'h0000;
            instr_reg <= NOP_INSTR;
            pc2_reg   <= 16'h0000;
            pred_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            pc2_reg   <= pc2_next;
            pred_reg  <= pred_next;
            valid_reg <= valid_next;
        end
    end

    assign PCF            = pc_reg;
    assign InstructionD   = instr_reg;
    assign PCPlus2D       = pc2_reg;
    assign PredictedTaken = pred_reg;
    assign ValidD         = valid_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// =============================================================================
// tb_fetch_stage
// -----------------------------------------------------------------------------
// Directed testbench for fetch_stage: a table of single-cycle vectors for the
// basic fetch/stall/wait/redirect behaviour, followed by hand-written
// sequences for predictor training, counter saturation, PC wrap, HLT and
// asynchronous reset.
// =============================================================================
module tb_fetch_stage;

`ifdef BHT_PREDICT_EN
    localparam bit PRED_ON = 1'b1;
`else
    localparam bit PRED_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] PCF;
    logic [15:0] InstrF;
    logic        IMemReady;
    logic        Stall;
    logic        BranchD;
    logic [15:0] BranchAddr;
    logic        ResolveValid;
    logic [15:0] ResolvePC;
    logic        ResolveTaken;
    logic [15:0] InstructionD;
    logic [15:0] PCPlus2D;
    logic        PredictedTaken;
    logic        ValidD;

    int total;
    int bad;

    fetch_stage #(
        .BHT_IDX_BITS(4),
        .NOP_INSTR   (16'h0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .PCF           (PCF),
        .InstrF        (InstrF),
        .IMemReady     (IMemReady),
        .Stall         (Stall),
        .BranchD       (BranchD),
        .BranchAddr    (BranchAddr),
        .ResolveValid  (ResolveValid),
        .ResolvePC     (ResolvePC),
        .ResolveTaken  (ResolveTaken),
        .InstructionD  (InstructionD),
        .PCPlus2D      (PCPlus2D),
        .PredictedTaken(PredictedTaken),
        .ValidD        (ValidD)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [15:0] instr;
        logic        ready;
        logic        stall;
        logic        br;
        logic [15:0] baddr;
        logic [15:0] e_pc;
        logic [15:0] e_instr;
        logic [15:0] e_p2;
        logic        e_pred;
        logic        e_valid;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [0:NVEC-1];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [15:0] e_pc, input logic [15:0] e_instr,
                             input logic [15:0] e_p2, input logic e_pred, input logic e_valid);
        chk({name, ".PCF"},            PCF,                     e_pc);
        chk({name, ".InstructionD"},   InstructionD,            e_instr);
        chk({name, ".PCPlus2D"},       PCPlus2D,                e_p2);
        chk({name, ".PredictedTaken"}, {15'd0, PredictedTaken}, {15'd0, e_pred});
        chk({name, ".ValidD"},         {15'd0, ValidD},         {15'd0, e_valid});
        $display("%s: PCF=%h ID=%h P2=%h pred=%b valid=%b", name, PCF, InstructionD, PCPlus2D,
                 PredictedTaken, ValidD);
    endtask

    // One clock cycle: drive inputs at the falling edge, sample 1 time unit
    // after the rising edge, then return at the next falling edge.
    task automatic step(input string name, input logic [15:0] instr, input logic ready,
                        input logic stall, input logic br, input logic [15:0] baddr,
                        input logic rv, input logic [15:0] rpc, input logic rt,
                        input logic [15:0] e_pc, input logic [15:0] e_instr,
                        input logic [15:0] e_p2, input logic e_pred, input logic e_valid);
        InstrF       = instr;
        IMemReady    = ready;
        Stall        = stall;
        BranchD      = br;
        BranchAddr   = baddr;
        ResolveValid = rv;
        ResolvePC    = rpc;
        ResolveTaken = rt;
        @(posedge clk);
        #1;
        check_all(name, e_pc, e_instr, e_p2, e_pred, e_valid);
        @(negedge clk);
    endtask

    logic [15:0] tk_pc;
    logic [15:0] n16;

    initial begin
        total = 0;
        bad   = 0;

        //            instr     rdy   stl   br    baddr     e_pc      e_instr   e_p2      pred  valid
        vecs[0]  = '{16'h0123, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0002, 16'h0123, 16'h0002, 1'b0, 1'b1};
        vecs[1]  = '{16'h0456, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0004, 16'h0456, 16'h0004, 1'b0, 1'b1};
        vecs[2]  = '{16'h0789, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0006, 16'h0789, 16'h0006, 1'b0, 1'b1};
        vecs[3]  = '{16'h0ABC, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[4]  = '{16'hC005, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[5]  = '{16'hC005, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[6]  = '{16'h1123, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0012, 16'h1123, 16'h0012, 1'b0, 1'b1};
        vecs[7]  = '{16'h0222, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0012, 16'h1123, 16'h0012, 1'b0, 1'b1};
        vecs[8]  = '{16'h0222, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0014, 16'h0222, 16'h0014, 1'b0, 1'b1};
        vecs[9]  = '{16'h0333, 1'b1, 1'b1, 1'b1, 16'h0040, 16'h0040, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[10] = '{16'hC005, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0042, 16'hC005, 16'h0042, 1'b0, 1'b1};
        vecs[11] = '{16'hD003, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0044, 16'hD003, 16'h0044, 1'b0, 1'b1};
        vecs[12] = '{16'h0555, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0044, 16'hD003, 16'h0044, 1'b0, 1'b1};

        n16          = 16'h0000;
        rst          = 1'b1;
        InstrF       = 16'h0000;
        IMemReady    = 1'b0;
        Stall        = 1'b0;
        BranchD      = 1'b0;
        BranchAddr   = 16'h0000;
        ResolveValid = 1'b0;
        ResolvePC    = 16'h0000;
        ResolveTaken = 1'b0;

        @(negedge clk);
        check_all("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            step($sformatf("vec%0d", i), vecs[i].instr, vecs[i].ready, vecs[i].stall, vecs[i].br,
                 vecs[i].baddr, 1'b0, n16, 1'b0,
                 vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_p2, vecs[i].e_pred, vecs[i].e_valid);
        end

        // Predictor training: two taken resolutions for PC 0x0020 (01 -> 11).
        tk_pc = PRED_ON ? 16'h002C : 16'h0022;
        step("train1", 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0020, 1'b1, 16'h0020, 1'b1,
             16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b0);
        step("train2", 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0020, 1'b1,
             16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b0);
        step("train_b", 16'hC005, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, n16, 1'b0,
             tk_pc, 16'hC005, 16'h0022, PRED_ON, 1'b1);

        // Untrain to 01, then fetch while a taken update hits the same entry:
        // prediction must use the old (not-taken) value.
        step("untrain1", 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0020, 1'b1, 16'h0020, 1'b0,
             16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b0);
        step("untrain2", 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0020, 1'b0,
             16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b0);
        step("nobypass", 16'hC005, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0020, 1'b1,
             16'h0022, 16'hC005, 16'h0022, 1'b0, 1'b1);
        step("redir_a", 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0020, 1'b0, n16, 1'b0,
             16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b0);
        step("after_upd", 16'hC005, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, n16, 1'b0,
             tk_pc, 16'hC005, 16'h0022, PRED_ON, 1'b1);

        // Saturation at 3: 10 -> 11 -> 11 -> 11, then one not-taken -> 10.
        step("sat_hi1", 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0020, 1'b1, 16'h0020, 1'b1,
             16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b0);
        step("sat_hi2", 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0020, 1'b1,
             16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b0);
        step("sat_hi3", 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0020, 1'b1,
             16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b0);
        step("sat_hi4", 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0020, 1'b0,
             16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b0);
        step("sat_hi_b", 16'hC005, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, n16, 1'b0,
             tk_pc, 16'hC005, 16'h0022, PRED_ON, 1'b1);

        // Saturation at 0: 10 -> 01 -> 00 -> 00, then two taken -> 10.
        step("sat_lo1", 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0020, 1'b1, 16'h0020, 1'b0,
             16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b0);
        step("sat_lo2", 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0020, 1'b0,
             16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b0);
        step("sat_lo3", 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0020, 1'b0,
             16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b0);
        step("sat_lo4", 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0020, 1'b1,
             16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b0);
        step("sat_lo5", 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0020, 1'b1,
             16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b0);
        step("sat_lo_b", 16'hC005, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, n16, 1'b0,
             tk_pc, 16'hC005, 16'h0022, PRED_ON, 1'b1);

        // PC wrap at the top of the address space.
        step("wrap_redir", 16'h0000, 1'b1, 1'b0, 1'b1, 16'hFFFE, 1'b0, n16, 1'b0,
             16'hFFFE, 16'h0000, 16'h0000, 1'b0, 1'b0);
        step("wrap", 16'h0123, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, n16, 1'b0,
             16'h0000, 16'h0123, 16'h0000, 1'b0, 1'b1);

        // HLT parks the PC and keeps re-fetching until a redirect.
        step("hlt_redir", 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0030, 1'b0, n16, 1'b0,
             16'h0030, 16'h0000, 16'h0000, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            InstrF = 16'hF000; IMemReady = 1'b1; Stall = 1'b0; BranchD = 1'b0;
            ResolveValid = 1'b0;
            @(posedge clk);
            #1;
            chk($sformatf("hlt%0d.PCF", k), PCF, 16'h0030);
            chk($sformatf("hlt%0d.InstructionD", k), InstructionD, 16'hF000);
            chk($sformatf("hlt%0d.ValidD", k), {15'd0, ValidD}, 16'h0001);
            $display("hlt%0d: PCF=%h ID=%h valid=%b", k, PCF, InstructionD, ValidD);
            @(negedge clk);
        end
        step("hlt_exit", 16'hF000, 1'b1, 1'b0, 1'b1, 16'h0050, 1'b0, n16, 1'b0,
             16'h0050, 16'h0000, 16'h0000, 1'b0, 1'b0);
        step("post_hlt", 16'h0777, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, n16, 1'b0,
             16'h0052, 16'h0777, 16'h0052, 1'b0, 1'b1);

        // Asynchronous reset mid-cycle, no clock edge needed.
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        // Entry 0 was left at 10 (taken); reset must restore weakly not-taken.
        step("rst_cnt", 16'hC005, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, n16, 1'b0,
             16'h0002, 16'hC005, 16'h0002, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage WISC pipeline; the producer side of the IF/ID interface that the decode stage consumes.
- Holds the PC, drives the instruction-memory address and owns the IF/ID pipeline register (InstructionD, PCPlus2D, PredictedTaken).
- Predicts B (opcode 4'hC) with a table of 2-bit counters.
- Accepts redirect (BranchD/BranchAddr) and Stall back from decode.

Parameters:
- BHT_IDX_BITS, 4, index width of the prediction table (2^BHT_IDX_BITS entries), indexed by PC[BHT_IDX_BITS:1].
- NOP_INSTR, 16'h0000, bubble encoding loaded into IF/ID on flush or memory wait (ADD $0,$0,$0).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- PCF  output  16  instruction-memory address (current PC)
- InstrF  input  16  instruction returned for PCF, same cycle
- IMemReady  input  1  InstrF valid this cycle; 0 = cache miss, wait
- Stall  input  1  decode stall; hold PC and IF/ID
- BranchD  input  1  misprediction redirect from decode
- BranchAddr  input  16  redirect target
- ResolveValid  input  1  a B/BR was resolved in decode this cycle (not stalled)
- ResolvePC  input  16  PC of the resolved branch
- ResolveTaken  input  1  actual outcome
- InstructionD  output  16  IF/ID instruction
- PCPlus2D  output  16  IF/ID PC+2
- PredictedTaken  output  1  IF/ID prediction bit
- ValidD  output  1  1 = IF/ID holds a real instruction, 0 = bubble

Behaviour:
- Reset (async, immediate): PCF=0, InstructionD=NOP_INSTR, PCPlus2D=0, PredictedTaken=0, ValidD=0, all counters=2'b01 (weakly not taken).
- PC+2 and branch target are computed mod 2^16 (0xFFFE+2 -> 0x0000).
- Branch target = PCF+2 + sign-extend({InstrF[8:0],1'b0}).
- Prediction, combinational:
  - PredF = (InstrF[15:12]==4'hC) & IMemReady & counter[PCF idx][1].
  - BR (4'hD) is never predicted.
- Next-state priority, evaluated each rising edge:
  1. BranchD: PCF<=BranchAddr; IF/ID<=bubble (NOP_INSTR, PCPlus2D=0, PredictedTaken=0, ValidD=0). BranchD overrides Stall if both are asserted.
  2. Stall: PCF and IF/ID hold.
  3. !IMemReady: PCF holds; IF/ID<=bubble.
  4. InstrF[15:12]==4'hF (HLT): PCF holds; IF/ID<=InstrF, ValidD=1. HLT is re-fetched every cycle until a redirect.
  5. Otherwise: IF/ID<={InstrF, PCF+2, PredF}, ValidD=1; PCF<=PredF ? target : PCF+2.
- Latency: one cycle from PCF presented to the instruction appearing in IF/ID.
- Redirect penalty: one bubble cycle.
- Counter update on ResolveValid, at entry ResolvePC[BHT_IDX_BITS:1]:
  - 2-bit saturating; increment if ResolveTaken, decrement otherwise.
  - Saturates at 3 and 0.
- Same-cycle read and update of one entry: the prediction uses the old value (no bypass); the update is visible the next cycle.
- Update proceeds regardless of Stall, IMemReady or BranchD.

Optional Feature:
- Macro BHT_PREDICT_EN.
- Defined: counter table and predicted-taken target path as above.
- Undefined: no table is instantiated; PredF=0 always, so every B is fetched not-taken and corrected by decode. Resolve* inputs are ignored.
- All other behaviour is identical with or without the macro.

Test Plan:
- Reset then IMemReady=1 with ADD words at 0,2,4 -> PCF steps 0,2,4,6; InstructionD follows one cycle behind; PCPlus2D 2,4,6; ValidD=1.
- IMemReady=0 for 2 cycles at PCF=0x0010 -> PCF holds 0x0010; two bubbles (ValidD=0, InstructionD=0x0000); fetch resumes.
- Stall=1 for 1 cycle with InstructionD=0x1123 -> PCF and IF/ID unchanged; next cycle advances normally.
- BranchD=1, BranchAddr=0x0040, asserted together with Stall=1 -> PCF=0x0040; IF/ID is a bubble.
- Counter training:
  - Two ResolveValid/ResolveTaken=1 pulses for PC 0x0020; then fetch 0xC005 (B, imm=5) at 0x0020.
  - Required: PredictedTaken=1; next PCF=0x0022+0x000A=0x002C.
  - With the macro undefined: PredictedTaken=0 and next PCF=0x0022.
- PCF=0xFFFE fetching ADD -> next PCF=0x0000, PCPlus2D=0x0000.
- HLT at 0x0030 -> PCF stays 0x0030 and IF/ID shows 0xF000 repeatedly.
